// File: rtl/stage_pkg.sv
// Shared types and constants for the stage progression controller.
package stage_pkg;

    localparam int NUM_STAGES_C = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        CLEARED = 2'd2,
        WIN     = 2'd3
    } state_e;

    localparam logic [NUM_STAGES_C-1:0] STAGE_NONE = 5'b00000;
    localparam logic [NUM_STAGES_C-1:0] STAGE_ALL  = 5'b11111;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector: rise_o is high for the cycle where
// d_i is 1 and was 0 at the previous clock edge.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/stage_controller.sv
// Game-level progression: start, thermometer stage advance, detector re-arm, win.
// Optional per-stage timeout is built when STAGE_TIMEOUT_EN is defined.
module stage_controller
    import stage_pkg::*;
#(
    parameter int NUM_STAGES     = NUM_STAGES_C,
    parameter int HOLD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  clear,
    output logic [NUM_STAGES-1:0] stage,
    output logic [2:0]            level,
    output logic                  stageReset,
    output logic                  win,
    output logic                  fail
);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255 ||
        TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1024) begin : g_bad_cfg
        $error("stage_controller: parameter out of range");
    end

    localparam logic [NUM_STAGES-1:0] STAGE_FIRST = 1;

    state_e                state_q, state_d;
    logic [7:0]            hold_q, hold_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic [2:0]            level_q, level_d;
    logic                  srst_q, srst_d;
    logic                  win_q, win_d;
    logic                  fail_q, fail_d;
    logic                  clr_rise;
    logic                  timeout;

    rise_detect u_clr_rise (
        .clk    (clk),
        .reset  (reset),
        .d_i    (clear),
        .rise_o (clr_rise)
    );

`ifdef STAGE_TIMEOUT_EN
    logic [9:0] to_q, to_d;

    // Counter is held at zero outside PLAY, so every PLAY entry starts fresh.
    always_comb begin
        to_d = '0;
        if (state_q == PLAY) to_d = to_q + 10'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) to_q <= '0;
        else       to_q <= to_d;
    end

    assign timeout = (state_q == PLAY) &&
                     (to_q == 10'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            stage_q <= STAGE_NONE;
            level_q <= '0;
            srst_q  <= 1'b1;
            win_q   <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            stage_q <= stage_d;
            level_q <= level_d;
            srst_q  <= srst_d;
            win_q   <= win_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, WIN: if (start) state_d = PLAY;
            PLAY: begin
                if (clr_rise)
                    state_d = (stage_q == STAGE_ALL) ? WIN : CLEARED;
                else if (timeout)
                    state_d = IDLE;
            end
            CLEARED: if (hold_q == 8'd0) state_d = PLAY;
        endcase
    end

    // Registered outputs are computed from the same transition conditions.
    always_comb begin
        hold_d  = hold_q;
        stage_d = stage_q;
        level_d = level_q;
        srst_d  = srst_q;
        win_d   = win_q;
        fail_d  = 1'b0;
        unique case (state_q)
            IDLE, WIN: begin
                if (start) begin
                    stage_d = STAGE_FIRST;
                    level_d = 3'd1;
                    srst_d  = 1'b0;
                    win_d   = 1'b0;
                end
            end
            PLAY: begin
                if (clr_rise) begin
                    srst_d = 1'b1;
                    if (stage_q == STAGE_ALL) win_d = 1'b1;
                    else hold_d = 8'(HOLD_CYCLES - 1);
                end else if (timeout) begin
                    fail_d  = 1'b1;
                    stage_d = STAGE_NONE;
                    level_d = '0;
                    srst_d  = 1'b1;
                end
            end
            CLEARED: begin
                if (hold_q == 8'd0) begin
                    stage_d = {stage_q[NUM_STAGES-2:0], 1'b1};
                    level_d = level_q + 3'd1;
                    srst_d  = 1'b0;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
        endcase
    end

    assign stage      = stage_q;
    assign level      = level_q;
    assign stageReset = srst_q;
    assign win        = win_q;
    assign fail       = fail_q;

endmodule

// File: tb/tb_stage_controller.sv
// Directed bench for stage_controller with a cycle model of the game rules.
module tb_stage_controller;

    localparam int HOLD = 4;
    localparam int TO   = 16;

    logic       clk = 1'b0;
    logic       reset, start, clear;
    logic [4:0] stage;
    logic [2:0] level;
    logic       stageReset, win, fail;

    int checks = 0;
    int errors = 0;
    bit armed  = 0;

    stage_controller #(
        .NUM_STAGES     (5),
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .clear      (clear),
        .stage      (stage),
        .level      (level),
        .stageReset (stageReset),
        .win        (win),
        .fail       (fail)
    );

    always #5 clk = ~clk;

    // Game model: current stage number, whether the detector is live,
    // remaining hold cycles, and the win flag.
    int m_lvl   = 0;
    bit m_play  = 0;
    bit m_win   = 0;
    int m_hold  = 0;
    bit m_prev  = 0;
    int m_ptime = 0;
    bit m_fail  = 0;

    always @(posedge clk) begin
        bit rise;
        rise   = clear && !m_prev;
        m_prev = clear;
        m_fail = 0;
        if (reset) begin
            m_lvl = 0; m_play = 0; m_win = 0;
            m_hold = 0; m_prev = 0; m_ptime = 0;
        end else if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) begin
                m_lvl++;
                m_play  = 1;
                m_ptime = 0;
            end
        end else if (m_play) begin
            if (rise) begin
                m_play = 0;
                if (m_lvl == 5) m_win = 1;
                else m_hold = HOLD;
            end
`ifdef STAGE_TIMEOUT_EN
            else if (m_ptime == TO - 1) begin
                m_fail = 1;
                m_play = 0;
                m_lvl  = 0;
            end else begin
                m_ptime++;
            end
`endif
        end else if (start) begin
            m_lvl = 1; m_play = 1; m_win = 0; m_ptime = 0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d",
                     name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            logic [4:0] es;
            es = 5'((1 << m_lvl) - 1);
            check("model_stage", int'(stage), int'(es));
            check("model_level", int'(level), m_lvl);
            check("model_srst", int'(stageReset), int'(!m_play));
            check("model_win", int'(win), int'(m_win));
            check("model_fail", int'(fail), int'(m_fail));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; clear = 1'b0;
        step(1);
        armed = 1;
        step(1);
        reset = 1'b0;
        step(1);
        check("rst_stage", int'(stage), 0);
        check("rst_srst", int'(stageReset), 1);
        check("rst_win", int'(win), 0);
        step(3);
        check("idle_stage", int'(stage), 0);
        check("idle_level", int'(level), 0);

        start = 1'b1; step(1); start = 1'b0;
        check("start_stage", int'(stage), 1);
        check("start_srst", int'(stageReset), 0);

        clear = 1'b1; step(1);
        check("clr_srst", int'(stageReset), 1);
        check("clr_stage", int'(stage), 1);
        step(3);
        check("hold_srst", int'(stageReset), 1);
        step(1);
        check("adv_stage", int'(stage), 5'b00011);
        check("adv_srst", int'(stageReset), 0);
        step(15);
        clear = 1'b0; step(2);
        check("held_stage", int'(stage), 5'b00011);
        pulse_clear(); step(HOLD + 2);
        check("s3_stage", int'(stage), 5'b00111);
        pulse_clear(); step(HOLD + 2);
        pulse_clear(); step(HOLD + 2);
        check("s5_stage", int'(stage), 5'b11111);
        check("s5_level", int'(level), 5);
        pulse_clear(); step(2);
        check("win_flag", int'(win), 1);
        check("win_srst", int'(stageReset), 1);
        pulse_clear(); step(3);
        check("win_hold", int'(stage), 5'b11111);

        start = 1'b1; clear = 1'b1; step(1);
        start = 1'b0; clear = 1'b0;
        check("restart_stage", int'(stage), 1);
        check("restart_win", int'(win), 0);
        step(2);

        start = 1'b1; clear = 1'b1; step(1);
        start = 1'b0; clear = 1'b0;
        check("rise_beats_start", int'(stageReset), 1);
        step(1);
        reset = 1'b1; step(1); reset = 1'b0;
        check("midhold_stage", int'(stage), 0);
        check("midhold_srst", int'(stageReset), 1);
        step(HOLD + 3);
        check("no_late_adv", int'(stage), 0);

`ifdef STAGE_TIMEOUT_EN
        start = 1'b1; step(1); start = 1'b0;
        step(TO - 1);
        check("to_before", int'(fail), 0);
        step(1);
        check("to_fail", int'(fail), 1);
        check("to_stage", int'(stage), 0);
        step(1);
        check("to_pulse", int'(fail), 0);
`endif
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage_controller.md
Name: stage_controller

Overview:
- Downstream consumer of the stage-clear detector's `clear` output.
- Owns the game-level progression: it starts play, then advances the 5-bit thermometer stage code that feeds back into the clear detector.
- Re-arms the clear detector between stages through a `stageReset` pulse, and declares a win after the final stage.
- Single clock domain; all outputs are registered.

Parameters:
- NUM_STAGES, 5, width of the thermometer `stage` bus and number of stages to clear for a win.
- HOLD_CYCLES, 4, clk cycles spent in CLEARED (detector held in reset) before the next stage is presented; legal range 1..255.
- TIMEOUT_CYCLES, 1000, per-stage cycle limit; used only when STAGE_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle start/restart request.
- clear  input  1  level from the stage-clear detector; high when the current stage is satisfied.
- stage  output  NUM_STAGES  thermometer stage code driven to the detector (00001 = stage 1).
- level  output  3  binary stage number, 0..NUM_STAGES (0 = idle).
- stageReset  output  1  active-high reset driven to the detector.
- win  output  1  high while in the WIN state.
- fail  output  1  one-cycle timeout pulse; constant 0 without STAGE_TIMEOUT_EN.

Behaviour:
- Reset values, applied at the next clk edge after reset=1 and taking priority over everything else including mid-operation:
  - state=IDLE, stage=0, level=0, stageReset=1, win=0, fail=0.
  - hold and timeout counters = 0; clear_d = 0.
- Edge detect: `clear_d` registers `clear`. `clr_rise = clear & ~clear_d`. Only `clr_rise` advances state; a held-high `clear` advances at most one stage.
- IDLE:
  - stage=0, stageReset=1.
  - start=1 -> PLAY at the next edge with stage=00001, level=1, stageReset=0.
- PLAY:
  - stageReset=0.
  - If clr_rise and stage is all ones -> WIN, stage held at 11111.
  - Else if clr_rise -> CLEARED, stageReset=1, hold counter loaded with HOLD_CYCLES-1.
  - start in PLAY is ignored.
- CLEARED:
  - stageReset=1; the hold counter decrements each cycle.
  - When the counter reaches 0: stage <= {stage[NUM_STAGES-2:0],1'b1}, level <= level+1, stageReset <= 0, state -> PLAY.
  - Net effect: exactly HOLD_CYCLES cycles with stageReset high, then the new stage is visible on the same edge that stageReset falls.
  - clear and start are ignored in CLEARED.
- WIN:
  - win=1, stageReset=1, stage=11111, level=5.
  - start=1 -> PLAY with stage=00001, level=1, win=0.
- Simultaneous events:
  - reset beats all other inputs.
  - In IDLE or WIN, start beats clear.
  - In PLAY, clr_rise beats start.
- Latency:
  - start to stage=00001: 1 cycle.
  - clr_rise to stageReset=1: 1 cycle.
  - clr_rise to next stage visible: 1 + HOLD_CYCLES cycles.
- Width rules:
  - `level` is the saturating count of ones in `stage` (max 5).
  - `stage` only ever holds thermometer values.

Optional Feature:
- Macro: STAGE_TIMEOUT_EN.
- Defined:
  - A 10-bit timeout counter clears on entry to PLAY and increments each PLAY cycle.
  - On reaching TIMEOUT_CYCLES-1 without clr_rise: fail=1 for one cycle, state -> IDLE, stage=0, level=0, stageReset=1.
  - clr_rise in that same cycle wins over the timeout.
- Undefined: no timeout counter is built; fail is tied to 0.

Decomposition:
- Shared package `stage_pkg` holds:
  - NUM_STAGES_C=5.
  - A state enum (IDLE=2'd0, PLAY=2'd1, CLEARED=2'd2, WIN=2'd3).
  - The thermometer constants STAGE_NONE=5'b00000 and STAGE_ALL=5'b11111.
- One natural sub-module, `rise_detect`: a registered rising-edge detector for `clear`, reusable for `start` debouncing.
- The FSM, hold counter and timeout counter stay in stage_controller.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, then 0 -> stage=00000, level=0, stageReset=1, win=0; unchanged with no start.
- Start and first clear: pulse start -> next edge stage=00001, stageReset=0. Raise clear -> stageReset=1 one cycle later. With HOLD_CYCLES=4, stage=00011 and stageReset=0 exactly 5 cycles after the clear edge.
- Held clear: hold clear=1 for 20 cycles after stage 1 -> only one advance (stage=00011); a second rise is required for 00111.
- Full game: five clear pulses each separated by more than 6 cycles -> stage walks 00001, 00011, 00111, 01111, 11111, then win=1 and level=5. start -> stage=00001, win=0.
- Reset mid-CLEARED: assert reset 2 cycles into the hold -> next edge state=IDLE, stage=00000, stageReset=1; no late stage advance.
- With STAGE_TIMEOUT_EN and TIMEOUT_CYCLES=16: start, then no clear -> fail=1 for exactly one cycle 16 cycles after entering PLAY, then stage=00000, level=0.
